// File: rtl/controller_snes_multi.sv
// Multi-port SNES / GameTank controller scanner: shared latch and clock lines,
// per-port serial data, results published atomically with a scan_done pulse.
module controller_snes_multi #(
  parameter int FREQ    = 21_500_000,
  parameter int PORTS   = 2,
  parameter int HALF_US = 6,
  parameter int WAIT_US = 16000,
  parameter int AUTO    = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  scan_req,
  output logic                  joy_strb,
  output logic                  joy_clk,
  input  logic [PORTS-1:0]      joy_data,
  output logic [12*PORTS-1:0]   buttons,
  output logic [PORTS-1:0]      present,
  output logic [PORTS-1:0]      is_gametank,
  output logic                  scan_done
);

  localparam int H       = (FREQ / 1_000_000) * HALF_US;
  localparam int W       = (FREQ / 1_000_000) * WAIT_US;
  localparam int CNT_MAX = (2 * H > W) ? 2 * H : W;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LATCH_END = CW'(2 * H);
  localparam logic [CW-1:0] HALF_END  = CW'(H - 1);
  localparam logic [CW-1:0] WAIT_END  = CW'(W - 1);
  localparam logic [4:0]    LAST_BIT  = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_CLK_HIGH = 3'd2,
    S_CLK_LOW  = 3'd3,
    S_WAIT     = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (AUTO != 0) ? S_LATCH : S_IDLE;

  // Inverted sample vector: bit 16 = presence, bits 15..12 nonzero = GameTank.
  function automatic logic is_gt_pad(input logic [16:0] s);
    return s[16] & (|s[15:12]);
  endfunction

  function automatic logic [11:0] decode_buttons(input logic [16:0] s);
    logic [11:0] b;
    if (!s[16]) begin
      b = 12'h000;
    end else if (|s[15:12]) begin
      b = {4'h0, s[7:0]};
    end else begin
      b = s[11:0];
    end
    return b;
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [4:0]               bit_q, bit_d;
  logic                     strb_q, strb_d;
  logic                     jclk_q, jclk_d;
  logic                     done_q, done_d;
  logic [PORTS-1:0][16:0]   shift_q, shift_d;
  logic [12*PORTS-1:0]      buttons_q, buttons_d;
  logic [PORTS-1:0]         present_q, present_d;
  logic [PORTS-1:0]         gt_q, gt_d;

  // Next-state, line timing, sampling and result publication.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    strb_d    = 1'b0;
    jclk_d    = 1'b1;
    done_d    = 1'b0;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    present_d = present_q;
    gt_d      = gt_q;

    case (state_q)
      S_IDLE: begin
        if ((AUTO == 0) && scan_req) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_END) begin
          state_d = S_CLK_HIGH;
          cnt_d   = '0;
          bit_d   = 5'd0;
        end else begin
          strb_d = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_CLK_HIGH: begin
        if (cnt_q == HALF_END) begin
          jclk_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_CLK_LOW;
          for (int p = 0; p < PORTS; p++) begin
            shift_d[p] = {~joy_data[p], shift_q[p][16:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLK_LOW: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            // The 17th sample is already in shift_q, so every port updates together here.
            done_d = 1'b1;
            for (int p = 0; p < PORTS; p++) begin
              buttons_d[12*p +: 12] = decode_buttons(shift_q[p]);
              present_d[p]          = shift_q[p][16];
              gt_d[p]               = is_gt_pad(shift_q[p]);
            end
            state_d = (AUTO != 0) ? S_WAIT : S_IDLE;
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = S_CLK_HIGH;
          end
        end else begin
          jclk_d = 1'b0;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
        bit_d   = 5'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      bit_q     <= 5'd0;
      strb_q    <= 1'b0;
      jclk_q    <= 1'b1;
      done_q    <= 1'b0;
      shift_q   <= '0;
      buttons_q <= '0;
      present_q <= '0;
      gt_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      strb_q    <= strb_d;
      jclk_q    <= jclk_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      present_q <= present_d;
      gt_q      <= gt_d;
    end
  end

  assign joy_strb    = strb_q;
  assign joy_clk     = jclk_q;
  assign scan_done   = done_q;
  assign buttons     = buttons_q;
  assign present     = present_q;
  assign is_gametank = gt_q;

endmodule

// File: doc/controller_snes_multi.md
CONTROLLER_SNES_MULTI -- requirements
Module: controller_snes_multi

Interface
REQ-001 SHALL have parameter FREQ, default 21_500_000, clk frequency in Hz.
REQ-002 SHALL have parameter PORTS, default 2, number of controller ports (1..4).
REQ-003 SHALL have parameter HALF_US, default 6, half clock period and latch half-width in microseconds.
REQ-004 SHALL have parameter WAIT_US, default 16000, idle gap between scans in microseconds (auto mode).
REQ-005 SHALL have parameter AUTO, default 1: 1 = free-running scans, 0 = scan only on scan_req.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset; one clock, asynchronous, active-low.
REQ-008 SHALL have port scan_req  input  1  start-scan request; used only when AUTO=0.
REQ-009 SHALL have port joy_strb  output  1  latch pulse, shared by all ports.
REQ-010 SHALL have port joy_clk  output  1  data clock, shared, idle high.
REQ-011 SHALL have port joy_data  input  PORTS  serial data per port; 0 = pressed, pulled up externally.
REQ-012 SHALL have port buttons  output  12*PORTS  port p at [12p+11:12p], 1 = pressed: (R L X A RT LT DN UP START SELECT Y B).
REQ-013 SHALL have port present  output  PORTS  1 = controller detected on port.
REQ-014 SHALL have port is_gametank  output  PORTS  1 = GameTank pad detected on port.
REQ-015 SHALL have port scan_done  output  1  one-cycle pulse when outputs update.

Function
REQ-016 SHALL define H = FREQ/1_000_000*HALF_US cycles and W = FREQ/1_000_000*WAIT_US cycles, integer arithmetic; counter width sized for max(2H, W).
REQ-017 SHALL implement states IDLE, LATCH, CLK_HIGH, CLK_LOW, WAIT.
REQ-018 IDLE (AUTO=0 only): joy_strb=0, joy_clk=1; scan_req=1 -> LATCH next cycle, counter cleared.
REQ-019 LATCH: joy_strb=1 for exactly 2H cycles, then joy_strb=0, bit index=0, -> CLK_HIGH.
REQ-020 CLK_HIGH: joy_clk=1 for H cycles; on last cycle drive joy_clk=0 and sample all joy_data bits simultaneously into per-port 17-bit shift registers (inverted, LSB-first), -> CLK_LOW.
REQ-021 CLK_LOW: joy_clk=0 for H cycles, then joy_clk=1; after 17th sample -> result stage, else bit index +1 and -> CLK_HIGH.
REQ-022 Exactly 17 clock pulses per scan; sample k (0-based) = button bit k for k<16; sample 16 = presence bit.
REQ-023 Per port, present=1 iff raw sample 16 read 0 (inverted bit 1).
REQ-024 Per port, is_gametank=1 iff present and inverted samples 12..15 not all 0.
REQ-025 Per port buttons: absent -> 0; GameTank -> {4'b0, samples[7:0]}; SNES -> samples[11:0].
REQ-026 buttons, present, is_gametank SHALL update for all ports in the same cycle, with scan_done=1 that cycle only.
REQ-027 After result: AUTO=1 -> WAIT for W cycles then LATCH; AUTO=0 -> IDLE.
REQ-028 scan_req asserted while not in IDLE SHALL be ignored (not queued); scan_req ignored when AUTO=1.
REQ-029 Outputs SHALL hold previous values between scan_done pulses; partial scans never visible.

Reset
REQ-030 resetn=0 SHALL immediately force joy_strb=0, joy_clk=1, buttons=0, present=0, is_gametank=0, scan_done=0, counter=0, bit index=0, shift registers=0.
REQ-031 Reset state SHALL be LATCH if AUTO=1, IDLE if AUTO=0; reset mid-scan abandons the scan with no output update.

Verification
REQ-032 FREQ=2_000_000, HALF_US=6 (H=12), AUTO=1, PORTS=2: after reset joy_strb high 24 cycles, then 17 joy_clk low pulses of 12 cycles each, 12-cycle high phases.
REQ-033 Port0 SNES model with B and R pressed, sample 16 low: scan_done -> buttons[11:0]=12'h801, present[0]=1, is_gametank[0]=0.
REQ-034 Port1 GameTank model (raw samples 12..15 = 0, A pressed bit 3): buttons[23:12]=12'h008, is_gametank[1]=1, upper 4 bits 0.
REQ-035 Port1 joy_data held 1 (unplugged): present[1]=0, buttons[23:12]=0, port0 unaffected.
REQ-036 AUTO=0: no activity until scan_req pulse; scan_req repeated mid-scan -> exactly one scan_done, then IDLE.
REQ-037 resetn asserted during CLK_LOW bit 9: outputs cleared asynchronously, no scan_done, fresh scan starts after release.
